// File: rtl/l2_axi_line_engine.sv
`default_nettype none
// ============================================================================
// Module   : l2_axi_line_engine
// Purpose  : AXI4 master moving whole L2 cache lines between the L2
//            miss/writeback queues and system memory. Independent read and
//            write channels, several bursts outstanding in each direction,
//            sticky bus-error reporting.
// Revision : 1.0  initial multi-outstanding line engine
// ============================================================================
module l2_axi_line_engine #(
    parameter int LINE_BITS      = 512,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int MAX_READS      = 4,
    parameter int MAX_WRITES     = 4,
    localparam int BEATS    = LINE_BITS / AXI_DATA_WIDTH,
    localparam int OFF_BITS = $clog2(LINE_BITS / 8),
    localparam int IDX_W    = ADDR_WIDTH - OFF_BITS,
    localparam int STRB_W   = AXI_DATA_WIDTH / 8
) (
    input  logic                      clk,
    input  logic                      reset_n,

    // Line read request / fill response
    input  logic                      rd_req_valid,
    output logic                      rd_req_ready,
    input  logic [IDX_W-1:0]          rd_req_addr,
    output logic                      rd_resp_valid,
    input  logic                      rd_resp_ready,
    output logic [LINE_BITS-1:0]      rd_resp_data,

    // Line writeback request
    input  logic                      wr_req_valid,
    output logic                      wr_req_ready,
    input  logic [IDX_W-1:0]          wr_req_addr,
    input  logic [LINE_BITS-1:0]      wr_req_data,
    output logic                      wr_done,
    output logic                      bus_error,

    // AXI read address channel
    output logic [3:0]                m_arid,
    output logic [ADDR_WIDTH-1:0]     m_araddr,
    output logic [7:0]                m_arlen,
    output logic [2:0]                m_arsize,
    output logic [1:0]                m_arburst,
    output logic [3:0]                m_arcache,
    output logic                      m_arvalid,
    input  logic                      m_arready,

    // AXI read data channel
    input  logic [AXI_DATA_WIDTH-1:0] s_rdata,
    input  logic [1:0]                s_rresp,
    input  logic                      s_rlast,
    input  logic                      s_rvalid,
    output logic                      m_rready,

    // AXI write address channel
    output logic [3:0]                m_awid,
    output logic [ADDR_WIDTH-1:0]     m_awaddr,
    output logic [7:0]                m_awlen,
    output logic [2:0]                m_awsize,
    output logic [1:0]                m_awburst,
    output logic [3:0]                m_awcache,
    output logic                      m_awvalid,
    input  logic                      m_awready,

    // AXI write data channel
    output logic [AXI_DATA_WIDTH-1:0] m_wdata,
    output logic [STRB_W-1:0]         m_wstrb,
    output logic                      m_wlast,
    output logic                      m_wvalid,
    input  logic                      m_wready,

    // AXI write response channel
    input  logic [1:0]                s_bresp,
    input  logic                      s_bvalid,
    output logic                      m_bready
);

    localparam int BEAT_W = $clog2(BEATS);
    localparam int CNTR_W = $clog2(MAX_READS + 1);
    localparam int CNTW_W = $clog2(MAX_WRITES + 1);

    localparam logic [CNTR_W-1:0] C_MAX_READS  = CNTR_W'(MAX_READS);
    localparam logic [CNTW_W-1:0] C_MAX_WRITES = CNTW_W'(MAX_WRITES);
    localparam logic [BEAT_W-1:0] C_BEAT_PENULT = BEAT_W'(BEATS - 2);
    localparam logic [7:0]        C_AXI_LEN    = 8'(BEATS - 1);
    localparam logic [2:0]        C_AXI_SIZE   = 3'($clog2(STRB_W));

    typedef enum logic [0:0] {
        W_IDLE = 1'b0,
        W_BUSY = 1'b1
    } wstate_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    wstate_t                 wstate_q,  wstate_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q,  wvalid_d;
    logic                    wlast_q,   wlast_d;
    logic [BEAT_W-1:0]       wbeat_q,   wbeat_d;
    logic [LINE_BITS-1:0]    wline_q,   wline_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q,  awaddr_d;
    logic [CNTW_W-1:0]       count_w_q, count_w_d;

    logic                    arvalid_q, arvalid_d;
    logic [ADDR_WIDTH-1:0]   araddr_q,  araddr_d;
    logic [CNTR_W-1:0]       count_r_q, count_r_d;
    logic [BEAT_W-1:0]       rbeat_q,   rbeat_d;
    logic [LINE_BITS-1:0]    rline_q,   rline_d;
    logic                    resp_valid_q, resp_valid_d;

    logic                    bus_error_q, bus_error_d;

    logic w_wr_accept;
    logic w_rd_accept;
    logic w_aw_hs;
    logic w_w_hs;
    logic w_r_hs;
    logic w_rlast_hs;

    // ------------------------------------------------------------------
    // Handshakes and request acceptance
    // ------------------------------------------------------------------
    assign wr_req_ready = (wstate_q == W_IDLE) && (count_w_q < C_MAX_WRITES);
    // Reads wait for every write to be acknowledged so a fill never sees
    // memory older than a writeback already handed to this block.
    assign rd_req_ready = !arvalid_q && (count_r_q < C_MAX_READS) &&
                          (count_w_q == '0) && !wr_req_valid &&
                          (wstate_q == W_IDLE);

    assign w_wr_accept = wr_req_valid && wr_req_ready;
    assign w_rd_accept = rd_req_valid && rd_req_ready;
    assign w_aw_hs     = awvalid_q && m_awready;
    assign w_w_hs      = wvalid_q && m_wready;
    assign w_r_hs      = s_rvalid && m_rready;
    assign w_rlast_hs  = w_r_hs && s_rlast;

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign m_arid    = 4'd0;
    assign m_araddr  = araddr_q;
    assign m_arlen   = C_AXI_LEN;
    assign m_arsize  = C_AXI_SIZE;
    assign m_arburst = 2'b01;
    assign m_arcache = 4'b0010;
    assign m_arvalid = arvalid_q;
    // The line buffer is single-entry: stop taking beats while a filled
    // line is still waiting for the requester.
    assign m_rready  = !resp_valid_q;

    assign m_awid    = 4'd0;
    assign m_awaddr  = awaddr_q;
    assign m_awlen   = C_AXI_LEN;
    assign m_awsize  = C_AXI_SIZE;
    assign m_awburst = 2'b01;
    assign m_awcache = 4'b0010;
    assign m_awvalid = awvalid_q;

    // The outgoing line is shifted up one beat per W handshake, so the
    // current beat is always the top slice of the register.
    assign m_wdata   = wline_q[LINE_BITS-1 -: AXI_DATA_WIDTH];
    assign m_wstrb   = {STRB_W{1'b1}};
    assign m_wlast   = wlast_q;
    assign m_wvalid  = wvalid_q;

    assign m_bready  = 1'b1;
    assign wr_done   = s_bvalid && reset_n;
    assign bus_error = bus_error_q;

    assign rd_resp_valid = resp_valid_q;
    assign rd_resp_data  = rline_q;

    // Write FSM next state: AW and W run independently, idle once both done
    always_comb begin
        wstate_d  = wstate_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        wlast_d   = wlast_q;
        wbeat_d   = wbeat_q;
        wline_d   = wline_q;
        awaddr_d  = awaddr_q;
        case (wstate_q)
            W_IDLE: begin
                if (w_wr_accept) begin
                    wstate_d  = W_BUSY;
                    awaddr_d  = {wr_req_addr, {OFF_BITS{1'b0}}};
                    wline_d   = wr_req_data;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    wlast_d   = 1'b0;
                    wbeat_d   = '0;
                end
            end
            W_BUSY: begin
                if (w_aw_hs) begin
                    awvalid_d = 1'b0;
                end
                if (w_w_hs) begin
                    wline_d = wline_q << AXI_DATA_WIDTH;
                    wbeat_d = wbeat_q + BEAT_W'(1);
                    wlast_d = (wbeat_q == C_BEAT_PENULT);
                    if (wlast_q) begin
                        wvalid_d = 1'b0;
                        wlast_d  = 1'b0;
                    end
                end
                if (!awvalid_d && !wvalid_d) begin
                    wstate_d = W_IDLE;
                end
            end
            default: begin
                wstate_d  = W_IDLE;
                awvalid_d = 1'b0;
                wvalid_d  = 1'b0;
                wlast_d   = 1'b0;
            end
        endcase
    end

    // Outstanding write count: +1 on acceptance, -1 on each B response
    always_comb begin
        count_w_d = count_w_q;
        if (w_wr_accept && !s_bvalid) begin
            count_w_d = count_w_q + CNTW_W'(1);
        end else if (!w_wr_accept && s_bvalid && (count_w_q != '0)) begin
            count_w_d = count_w_q - CNTW_W'(1);
        end
    end

    // Read path next state: AR issue, beat placement, fill hand-off
    always_comb begin
        arvalid_d    = arvalid_q;
        araddr_d     = araddr_q;
        rbeat_d      = rbeat_q;
        rline_d      = rline_q;
        resp_valid_d = resp_valid_q;
        count_r_d    = count_r_q;

        if (w_rd_accept) begin
            arvalid_d = 1'b1;
            araddr_d  = {rd_req_addr, {OFF_BITS{1'b0}}};
        end else if (arvalid_q && m_arready) begin
            arvalid_d = 1'b0;
        end

        if (w_r_hs) begin
            // Beat k lands in the k-th most-significant slice of the line.
            rline_d[AXI_DATA_WIDTH*(BEATS-1-int'(rbeat_q)) +: AXI_DATA_WIDTH] = s_rdata;
            if (s_rlast) begin
                rbeat_d      = '0;
                resp_valid_d = 1'b1;
            end else begin
                rbeat_d = rbeat_q + BEAT_W'(1);
            end
        end

        if (resp_valid_q && rd_resp_ready) begin
            resp_valid_d = 1'b0;
        end

        if (w_rd_accept && !w_rlast_hs) begin
            count_r_d = count_r_q + CNTR_W'(1);
        end else if (!w_rd_accept && w_rlast_hs && (count_r_q != '0)) begin
            count_r_d = count_r_q - CNTR_W'(1);
        end
    end

    // Sticky error flag: any non-OKAY read or write response
    always_comb begin
        bus_error_d = bus_error_q;
        if ((s_bvalid && (s_bresp != 2'b00)) || (w_r_hs && (s_rresp != 2'b00))) begin
            bus_error_d = 1'b1;
        end
    end

    // Write-side registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wstate_q  <= W_IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            wlast_q   <= 1'b0;
            wbeat_q   <= '0;
            wline_q   <= '0;
            awaddr_q  <= '0;
            count_w_q <= '0;
        end else begin
            wstate_q  <= wstate_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            wlast_q   <= wlast_d;
            wbeat_q   <= wbeat_d;
            wline_q   <= wline_d;
            awaddr_q  <= awaddr_d;
            count_w_q <= count_w_d;
        end
    end

    // Read-side registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            arvalid_q    <= 1'b0;
            araddr_q     <= '0;
            count_r_q    <= '0;
            rbeat_q      <= '0;
            rline_q      <= '0;
            resp_valid_q <= 1'b0;
        end else begin
            arvalid_q    <= arvalid_d;
            araddr_q     <= araddr_d;
            count_r_q    <= count_r_d;
            rbeat_q      <= rbeat_d;
            rline_q      <= rline_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    // Error flag register, cleared only by reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus_error_q <= 1'b0;
        end else begin
            bus_error_q <= bus_error_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_l2_axi_line_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_l2_axi_line_engine
// Purpose  : Self-checking bench: AXI slave + requester stimulus, with a
//            transaction-level model of outstanding work compared every cycle.
// Revision : 1.0  initial bench
// ============================================================================
module tb_l2_axi_line_engine;

    localparam int LINE_BITS = 512;
    localparam int DW        = 32;
    localparam int AW        = 32;
    localparam int BEATS     = 16;
    localparam int OFF       = 6;
    localparam int IDXW      = AW - OFF;
    localparam int MAXR      = 4;
    localparam int MAXW      = 4;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic                 rd_req_valid, rd_req_ready, rd_resp_valid, rd_resp_ready;
    logic [IDXW-1:0]      rd_req_addr, wr_req_addr;
    logic [LINE_BITS-1:0] rd_resp_data, wr_req_data;
    logic                 wr_req_valid, wr_req_ready, wr_done, bus_error;
    logic [3:0]           m_arid, m_awid, m_arcache, m_awcache;
    logic [AW-1:0]        m_araddr, m_awaddr;
    logic [7:0]           m_arlen, m_awlen;
    logic [2:0]           m_arsize, m_awsize;
    logic [1:0]           m_arburst, m_awburst, s_rresp, s_bresp;
    logic                 m_arvalid, m_arready, s_rlast, s_rvalid, m_rready;
    logic                 m_awvalid, m_awready, m_wlast, m_wvalid, m_wready;
    logic                 s_bvalid, m_bready;
    logic [DW-1:0]        s_rdata, m_wdata;
    logic [DW/8-1:0]      m_wstrb;

    l2_axi_line_engine dut (
        .clk(clk), .reset_n(reset_n),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
        .rd_resp_valid(rd_resp_valid), .rd_resp_ready(rd_resp_ready), .rd_resp_data(rd_resp_data),
        .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready), .wr_req_addr(wr_req_addr),
        .wr_req_data(wr_req_data), .wr_done(wr_done), .bus_error(bus_error),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arcache(m_arcache), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid), .m_rready(m_rready),
        .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
        .m_awburst(m_awburst), .m_awcache(m_awcache), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .m_bready(m_bready)
    );

    // ---------------- bookkeeping ----------------
    int n_chk = 0;
    int n_pass = 0;
    longint cyc = 0;

    // slave / requester knobs (percent probabilities)
    int p_aw = 100, p_w = 100, p_ar = 100, p_r = 100, p_b = 100, p_rr = 100;
    int aw_delay = -1;
    int r_lat = 0;
    int hold_n = 0;
    bit err_r3 = 0, rand_err = 0, req_en = 1;

    // requester queues
    logic [IDXW-1:0]      wq_addr[$];
    logic [LINE_BITS-1:0] wq_data[$];
    logic [IDXW-1:0]      rq_addr[$];

    // transaction-level model
    bit                   wr_busy, aw_seen, wl_seen, berr_m;
    logic [IDXW-1:0]      cur_waddr;
    logic [LINE_BITS-1:0] cur_wdata;
    int                   cur_wbeat;
    int                   n_wr_out, n_rd_out, n_ar_pend, n_avail;
    logic [IDXW-1:0]      exp_araddr[$];
    logic [LINE_BITS-1:0] exp_line[$];

    // slave state
    int                   s_aw_cnt, s_wl_cnt, s_b_issued, aw_wait, r_beat, hold_cnt;
    logic [AW-1:0]        s_arq[$];
    longint               s_arq_t[$];
    bit                   r_act, r_hold;
    logic [AW-1:0]        r_addr;

    // previous-cycle view of the fill port
    bit                   prev_rv, prev_rr;
    logic [LINE_BITS-1:0] prev_data;

    // captures for directed expectations
    logic [AW-1:0] cap_aw;
    logic [DW-1:0] cap_w0, cap_w15, cap_resp0;
    longint wacc_cyc, wl_cyc, aw_hs_cyc, last_b_cyc, rd_acc_cyc;
    int n_wrdone, n_resp, max_rd_out;

    function automatic bit roll(input int p);
        return $urandom_range(99) < p;
    endfunction

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a, input int k);
        return a ^ (32'(k) * 32'h01010101) ^ 32'hA500_0000;
    endfunction

    function automatic logic [LINE_BITS-1:0] line_of(input logic [IDXW-1:0] idx);
        logic [LINE_BITS-1:0] l;
        l = '0;
        for (int k = 0; k < BEATS; k++) l[LINE_BITS-1-DW*k -: DW] = pat({idx, 6'b0}, k);
        return l;
    endfunction

    task automatic check(input string name, input logic [LINE_BITS-1:0] act,
                         input logic [LINE_BITS-1:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        else n_pass++;
    endtask

    task automatic clear_model();
        wq_addr.delete(); wq_data.delete(); rq_addr.delete();
        exp_araddr.delete(); exp_line.delete(); s_arq.delete(); s_arq_t.delete();
        wr_busy = 0; aw_seen = 0; wl_seen = 0; berr_m = 0; cur_wbeat = 0;
        n_wr_out = 0; n_rd_out = 0; n_ar_pend = 0; n_avail = 0;
        s_aw_cnt = 0; s_wl_cnt = 0; s_b_issued = 0; aw_wait = 0; r_beat = 0; hold_cnt = 0;
        r_act = 0; r_hold = 0; prev_rv = 0; prev_rr = 0; prev_data = '0;
    endtask

    task automatic zero_inputs();
        rd_req_valid = 0; rd_req_addr = '0; rd_resp_ready = 0;
        wr_req_valid = 0; wr_req_addr = '0; wr_req_data = '0;
        m_arready = 0; s_rdata = '0; s_rresp = 2'b00; s_rlast = 0; s_rvalid = 0;
        m_awready = 0; m_wready = 0; s_bresp = 2'b00; s_bvalid = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valids"}, {m_awvalid, m_wvalid, m_wlast, m_arvalid, rd_resp_valid}, 5'b0);
        check({tag, "_wr_done"}, wr_done, 1'b0);
        check({tag, "_bus_error"}, bus_error, 1'b0);
        check({tag, "_bready"}, m_bready, 1'b1);
        check({tag, "_rready"}, m_rready, 1'b1);
    endtask

    // One clock: drive at posedge+1, compare at posedge+2, advance model.
    task automatic cycle();
        bit aw_hs, w_hs, ar_hs, r_hs, b_hs, resp_hs, wr_acc, rd_acc, mw_rdy, mr_rdy;
        int pend;
        // requester
        wr_req_valid = 0; wr_req_addr = '0; wr_req_data = '0;
        if (req_en && wq_addr.size() > 0) begin
            wr_req_valid = 1; wr_req_addr = wq_addr[0]; wr_req_data = wq_data[0];
        end
        rd_req_valid = 0; rd_req_addr = '0;
        if (req_en && rq_addr.size() > 0) begin
            rd_req_valid = 1; rd_req_addr = rq_addr[0];
        end
        if (hold_n > 0) rd_resp_ready = rd_resp_valid && (hold_cnt >= hold_n);
        else            rd_resp_ready = roll(p_rr);
        // slave
        if (aw_delay >= 0) m_awready = m_awvalid && (aw_wait >= aw_delay);
        else               m_awready = roll(p_aw);
        m_wready  = roll(p_w);
        m_arready = roll(p_ar);
        pend = ((s_aw_cnt < s_wl_cnt) ? s_aw_cnt : s_wl_cnt) - s_b_issued;
        s_bvalid = (pend > 0) && roll(p_b);
        s_bresp  = (s_bvalid && rand_err && roll(10)) ? 2'b10 : 2'b00;
        if (!r_act && s_arq.size() > 0 && cyc >= s_arq_t[0]) begin
            r_act = 1; r_addr = s_arq.pop_front(); void'(s_arq_t.pop_front()); r_beat = 0;
        end
        if (!r_hold) begin
            s_rvalid = r_act && roll(p_r);
            s_rresp  = ((err_r3 && r_beat == 3) || (rand_err && roll(3))) ? 2'b10 : 2'b00;
        end
        s_rdata = pat(r_addr, r_beat);
        s_rlast = (r_beat == BEATS - 1);
        #1;
        // compare against the model
        mw_rdy = !wr_busy && (n_wr_out < MAXW);
        mr_rdy = (n_ar_pend == 0) && (n_rd_out < MAXR) && (n_wr_out == 0) && !wr_req_valid && !wr_busy;
        check("wr_req_ready", wr_req_ready, mw_rdy);
        check("rd_req_ready", rd_req_ready, mr_rdy);
        check("m_awvalid", m_awvalid, wr_busy && !aw_seen);
        check("m_wvalid", m_wvalid, wr_busy && !wl_seen);
        check("m_arvalid", m_arvalid, n_ar_pend > 0);
        check("rd_resp_valid", rd_resp_valid, n_avail > 0);
        check("m_rready", m_rready, n_avail == 0);
        check("wr_done", wr_done, s_bvalid);
        check("bus_error", bus_error, berr_m);
        check("m_bready", m_bready, 1'b1);
        if (m_awvalid) begin
            check("m_awaddr", m_awaddr, {cur_waddr, 6'b0});
            check("aw_attr", {m_awid, m_awlen, m_awsize, m_awburst, m_awcache},
                  {4'd0, 8'd15, 3'd2, 2'b01, 4'b0010});
        end
        if (m_wvalid) begin
            check("m_wdata", m_wdata, cur_wdata[LINE_BITS-1-DW*cur_wbeat -: DW]);
            check("m_wlast", m_wlast, cur_wbeat == BEATS - 1);
            check("m_wstrb", m_wstrb, 4'hF);
        end
        if (m_arvalid && exp_araddr.size() > 0) begin
            check("m_araddr", m_araddr, {exp_araddr[0], 6'b0});
            check("ar_attr", {m_arid, m_arlen, m_arsize, m_arburst, m_arcache},
                  {4'd0, 8'd15, 3'd2, 2'b01, 4'b0010});
        end
        if (prev_rv && !prev_rr && rd_resp_valid)
            check("rd_resp_hold", rd_resp_data, prev_data);
        // handshakes at the coming edge
        aw_hs   = m_awvalid && m_awready;
        w_hs    = m_wvalid && m_wready;
        ar_hs   = m_arvalid && m_arready;
        r_hs    = s_rvalid && m_rready;
        b_hs    = s_bvalid;
        resp_hs = rd_resp_valid && rd_resp_ready;
        wr_acc  = wr_req_valid && mw_rdy;
        rd_acc  = rd_req_valid && mr_rdy;
        if (aw_hs) begin
            aw_seen = 1; s_aw_cnt++; aw_hs_cyc = cyc; cap_aw = m_awaddr; aw_wait = 0;
        end else if (m_awvalid) aw_wait++;
        if (w_hs) begin
            if (cur_wbeat == 0) cap_w0 = m_wdata;
            if (cur_wbeat == BEATS - 1) begin
                cap_w15 = m_wdata; wl_seen = 1; s_wl_cnt++; wl_cyc = cyc;
            end
            cur_wbeat++;
        end
        if (wr_busy && aw_seen && wl_seen) wr_busy = 0;
        if (wr_acc) begin
            wr_busy = 1; aw_seen = 0; wl_seen = 0; cur_wbeat = 0; wacc_cyc = cyc;
            cur_waddr = wq_addr.pop_front(); cur_wdata = wq_data.pop_front(); n_wr_out++;
        end
        if (b_hs) begin
            n_wr_out--; s_b_issued++; n_wrdone++; last_b_cyc = cyc;
            if (s_bresp != 2'b00) berr_m = 1;
        end
        if (ar_hs) begin
            n_ar_pend--; void'(exp_araddr.pop_front());
            s_arq.push_back(m_araddr); s_arq_t.push_back(cyc + r_lat);
        end
        r_hold = s_rvalid && !r_hs;
        if (r_hs) begin
            if (s_rresp != 2'b00) berr_m = 1;
            if (s_rlast) begin r_act = 0; n_rd_out--; n_avail++; end
            else r_beat++;
        end
        if (resp_hs) begin
            n_avail--;
            if (n_resp == 0) cap_resp0 = rd_resp_data[LINE_BITS-1 -: DW];
            n_resp++;
            if (exp_line.size() > 0) check("rd_resp_data", rd_resp_data, exp_line.pop_front());
            else check("rd_resp_valid_extra", rd_resp_valid, 1'b0);
            hold_cnt = 0;
        end else if (rd_resp_valid) hold_cnt++;
        if (rd_acc) begin
            n_rd_out++; n_ar_pend++; rd_acc_cyc = cyc;
            exp_araddr.push_back(rd_req_addr); exp_line.push_back(line_of(rd_req_addr));
            void'(rq_addr.pop_front());
            if (n_rd_out > max_rd_out) max_rd_out = n_rd_out;
        end
        prev_rv = rd_resp_valid; prev_rr = rd_resp_ready; prev_data = rd_resp_data;
        @(posedge clk); #1;
        cyc++;
    endtask

    function automatic bit all_idle();
        return wq_addr.size() == 0 && rq_addr.size() == 0 && !wr_busy && n_wr_out == 0 &&
               n_rd_out == 0 && n_ar_pend == 0 && n_avail == 0 && !r_act && s_arq.size() == 0;
    endfunction

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (!all_idle() && n < budget) begin cycle(); n++; end
        if (!all_idle()) begin
            n_chk++;
            $display("FAIL drain_%s: still busy after %0d cycles, required idle", name, budget);
        end
        repeat (2) cycle();
    endtask

    task automatic apply_reset(input string tag);
        reset_n = 0; zero_inputs(); #1;
        check_reset_outputs(tag);
        clear_model();
        repeat (3) @(posedge clk);
        #1; reset_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic push_wr(input logic [IDXW-1:0] a, input logic [LINE_BITS-1:0] d);
        wq_addr.push_back(a); wq_data.push_back(d);
    endtask

    initial begin
        logic [LINE_BITS-1:0] ids;
        int n;
        reset_n = 0; zero_inputs(); clear_model();
        #12;
        check_reset_outputs("por");
        check("por_wr_req_ready", wr_req_ready, 1'b1);
        @(posedge clk); #1; reset_n = 1;
        @(posedge clk); #1;

        // single write, line index 0x40, beat k carries value k
        ids = '0;
        for (int k = 0; k < BEATS; k++) ids[LINE_BITS-1-DW*k -: DW] = 32'(k);
        n_wrdone = 0;
        push_wr(26'h40, ids);
        drain("single_write", 200);
        check("s1_awaddr", cap_aw, 32'h0000_1000);
        check("s1_beat0", cap_w0, 32'd0);
        check("s1_beat15", cap_w15, 32'd15);
        check("s1_burst_cycles", 64'(wl_cyc - wacc_cyc), 64'd16);
        check("s1_wr_done_count", 32'(n_wrdone), 32'd1);

        // AW held off: mid-burst, then past the whole W burst
        aw_delay = 5;
        push_wr(26'h123, {16{32'hDEAD_BEEF}});
        drain("aw_delay5", 200);
        check("s2_aw_mid_burst", 1'(aw_hs_cyc < wl_cyc), 1'b1);
        aw_delay = 20;
        push_wr(26'h124, {16{$urandom}});
        drain("aw_delay20", 200);
        check("s2_w_before_aw", 1'(wl_cyc < aw_hs_cyc), 1'b1);
        aw_delay = -1;

        // five reads with a 10-cycle data latency
        r_lat = 10; n_resp = 0; max_rd_out = 0;
        for (int i = 0; i < 5; i++) rq_addr.push_back(26'h80 + 26'(i));
        drain("reads", 400);
        check("s3_max_outstanding", 32'(max_rd_out), 32'd4);
        check("s3_resp_count", 32'(n_resp), 32'd5);
        check("s3_first_word", cap_resp0, 32'hA500_2000);
        r_lat = 0;

        // write and read presented together
        p_b = 30;
        push_wr(26'h200, {16{32'h1234_5678}});
        rq_addr.push_back(26'h200);
        drain("wr_rd_same", 400);
        check("s4_read_after_b", 1'(rd_acc_cyc > last_b_cyc), 1'b1);
        p_b = 100;

        // requester stalls a filled line for 8 cycles
        hold_n = 8; n_resp = 0;
        rq_addr.push_back(26'h300); rq_addr.push_back(26'h301);
        drain("resp_hold", 400);
        check("s5_resp_count", 32'(n_resp), 32'd2);
        hold_n = 0;

        // error on beat 3 of a read, then reset in the middle of a write
        err_r3 = 1; n_resp = 0;
        rq_addr.push_back(26'h3FF);
        drain("rd_err", 200);
        check("s6_bus_error", bus_error, 1'b1);
        check("s6_line_delivered", 32'(n_resp), 32'd1);
        err_r3 = 0;
        p_w = 50;
        push_wr(26'h77, {16{32'hCAFE_F00D}});
        n = 0;
        while (!(m_wvalid && cur_wbeat >= 4) && n < 200) begin cycle(); n++; end
        check("s6_bus_error_sticky", bus_error, 1'b1);
        apply_reset("midrst");
        check("s6_post_reset_ready", wr_req_ready, 1'b1);

        // randomized traffic
        rand_err = 1;
        for (int seg = 0; seg < 4; seg++) begin
            p_aw = $urandom_range(30, 100); p_w = $urandom_range(30, 100);
            p_ar = $urandom_range(30, 100); p_r = $urandom_range(30, 100);
            p_b  = $urandom_range(20, 100); p_rr = $urandom_range(20, 100);
            r_lat = $urandom_range(0, 12);
            for (int c = 0; c < 700; c++) begin
                if (wq_addr.size() < 2 && roll(6))
                    push_wr(IDXW'($urandom), {$urandom, $urandom, $urandom, $urandom,
                                             $urandom, $urandom, $urandom, $urandom,
                                             $urandom, $urandom, $urandom, $urandom,
                                             $urandom, $urandom, $urandom, $urandom});
                if (rq_addr.size() < 3 && roll(10)) rq_addr.push_back(IDXW'($urandom));
                cycle();
            end
            drain("random", 2000);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
